rom_fetch_ctrl: RTL and testbench

//  Instruction-fetch sequencer for the dual-word single-port ROM (even/odd outputs, mem[addr] and mem[addr+1]).

---
 rtl/rom_fetch_ctrl.sv | 119 +++++++++++
 tb/tb_rom_fetch_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_fetch_ctrl.sv
// Instruction-fetch sequencer: walks a PC over a dual-word ROM, queues up to two words
// per cycle in a small FIFO and hands them to decode one per cycle over valid/ready.
module rom_fetch_ctrl #(
   parameter int WIDTH    = 32,
   parameter int AWIDTH   = 30,
   parameter int DEPTH    = 2048,
   parameter int QDEPTH   = 4,
   parameter int RESET_PC = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    stop,
   input  logic                    redirect_vld,
   input  logic [AWIDTH-1:0]       redirect_pc,
   output logic                    rom_cs,
   output logic [AWIDTH-1:0]       rom_addr,
   input  logic [WIDTH-1:0]        rom_dout_eve,
   input  logic [WIDTH-1:0]        rom_dout_odd,
   output logic                    inst_vld,
   input  logic                    inst_rdy,
   output logic [WIDTH-1:0]        inst_data,
   output logic [AWIDTH-1:0]       inst_pc,
   output logic [$clog2(QDEPTH):0] q_count,
   output logic                    busy
);
   localparam int PW = $clog2(QDEPTH);
   localparam int CW = PW + 1;
   localparam logic [AWIDTH-1:0] LAST_PC = AWIDTH'(DEPTH - 1);
   localparam logic [AWIDTH-1:0] PEN_PC  = AWIDTH'(DEPTH - 2);

   typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [AWIDTH-1:0] pc_q, pc_d;
   logic [CW-1:0]     count_q, count_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [WIDTH-1:0]  data_q [QDEPTH];
   logic [WIDTH-1:0]  data_d [QDEPTH];
   logic [AWIDTH-1:0] ipc_q [QDEPTH];
   logic [AWIDTH-1:0] ipc_d [QDEPTH];
   logic              pop;
   logic              at_last;
   logic [CW-1:0]     push_n;

   always_comb begin
      at_last  = (pc_q == LAST_PC);
      // Free space is judged from the registered count only, so a same-cycle pop never enables a fetch.
      rom_cs   = (state_q == FETCH) && !redirect_vld && (count_q <= CW'(QDEPTH - 2));
      rom_addr = pc_q;
      inst_vld = (count_q != '0) && !redirect_vld;
      pop      = inst_vld && inst_rdy;
      push_n   = '0;
      if (rom_cs) begin
         push_n = at_last ? CW'(1) : CW'(2);
      end

      state_d  = state_q;
      pc_d     = pc_q;
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      data_d   = data_q;
      ipc_d    = ipc_q;

      if (redirect_vld) begin
         pc_d     = redirect_pc % AWIDTH'(DEPTH);
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end else begin
         if (rom_cs) begin
            data_d[wr_ptr_q] = rom_dout_eve;
            ipc_d[wr_ptr_q]  = pc_q;
            // The odd word lies past the end of the ROM when pc is the last address.
            if (!at_last) begin
               data_d[wr_ptr_q + PW'(1)] = rom_dout_odd;
               ipc_d[wr_ptr_q + PW'(1)]  = pc_q + AWIDTH'(1);
            end
            pc_d = (at_last || pc_q == PEN_PC) ? '0 : pc_q + AWIDTH'(2);
         end
         wr_ptr_d = wr_ptr_q + push_n[PW-1:0];
         rd_ptr_d = rd_ptr_q + PW'(pop);
         count_d  = count_q + push_n - CW'(pop);
         if (stop) begin
            state_d = IDLE;
         end else if (start) begin
            state_d = FETCH;
         end
      end

      inst_data = data_q[rd_ptr_q];
      inst_pc   = ipc_q[rd_ptr_q];
      q_count   = count_q;
      busy      = (state_q == FETCH);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         pc_q     <= AWIDTH'(RESET_PC);
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         data_q   <= '{default: '0};
         ipc_q    <= '{default: '0};
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         data_q   <= data_d;
         ipc_q    <= ipc_d;
      end
   end

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Bench for rom_fetch_ctrl: ROM holds mem[i]=i; a queue-of-PCs model predicts every
// observable output each cycle, plus directed scenarios for stall, redirect, wrap, stop and reset.
module tb_rom_fetch_ctrl;
   localparam int WIDTH    = 32;
   localparam int AWIDTH   = 30;
   localparam int DEPTH    = 2048;
   localparam int QDEPTH   = 4;
   localparam int RESET_PC = 0;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              stop = 1'b0;
   logic              redirect_vld = 1'b0;
   logic [AWIDTH-1:0] redirect_pc = '0;
   logic              rom_cs;
   logic [AWIDTH-1:0] rom_addr;
   logic [WIDTH-1:0]  rom_dout_eve;
   logic [WIDTH-1:0]  rom_dout_odd;
   logic              inst_vld;
   logic              inst_rdy = 1'b0;
   logic [WIDTH-1:0]  inst_data;
   logic [AWIDTH-1:0] inst_pc;
   logic [2:0]        q_count;
   logic              busy;

   int checks = 0;
   int passes = 0;

   int mq[$];
   int m_pc = RESET_PC;
   bit m_fetch = 1'b0;
   bit exp_vld;
   bit exp_cs;

   always #5 clk = ~clk;

   assign rom_dout_eve = WIDTH'(rom_addr);
   assign rom_dout_odd = WIDTH'(rom_addr) + 32'd1;

   rom_fetch_ctrl #(
      .WIDTH(WIDTH), .AWIDTH(AWIDTH), .DEPTH(DEPTH), .QDEPTH(QDEPTH), .RESET_PC(RESET_PC)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop),
      .redirect_vld(redirect_vld), .redirect_pc(redirect_pc),
      .rom_cs(rom_cs), .rom_addr(rom_addr),
      .rom_dout_eve(rom_dout_eve), .rom_dout_odd(rom_dout_odd),
      .inst_vld(inst_vld), .inst_rdy(inst_rdy), .inst_data(inst_data), .inst_pc(inst_pc),
      .q_count(q_count), .busy(busy)
   );

   // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
   task automatic drive(input bit st, input bit sp, input bit rv, input int rpc, input bit rdy, input bit rs);
      start        = st;
      stop         = sp;
      redirect_vld = rv;
      redirect_pc  = AWIDTH'(rpc);
      inst_rdy     = rdy;
      rst          = rs;
      #1;
      exp_vld = (mq.size() != 0) && !rv;
      exp_cs  = m_fetch && !rv && (QDEPTH - mq.size() >= 2);
   endtask

   task automatic tick();
      int n;
      @(posedge clk);
      if (rst) begin
         mq.delete();
         m_pc    = RESET_PC;
         m_fetch = 1'b0;
      end else if (redirect_vld) begin
         mq.delete();
         m_pc = int'(redirect_pc) % DEPTH;
      end else begin
         n = 0;
         if (mq.size() != 0 && inst_rdy) void'(mq.pop_front());
         if (m_fetch && (QDEPTH - mq.size() - (exp_vld && inst_rdy ? 1 : 0) >= 2)) begin
            mq.push_back(m_pc);
            n = 1;
            if (m_pc != DEPTH - 1) begin
               mq.push_back(m_pc + 1);
               n = 2;
            end
            m_pc = (m_pc + n) % DEPTH;
         end
         if (stop) m_fetch = 1'b0;
         else if (start) m_fetch = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0, 1);
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      drive(0, 0, 0, 0, 1, 0);
      checks++; if (inst_vld !== 1'b0) $display("[TB] FAIL reset_vld: got %0b want 0", inst_vld); else passes++;
      checks++; if (rom_cs !== 1'b0) $display("[TB] FAIL reset_cs: got %0b want 0", rom_cs); else passes++;
      checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %0b want 0", busy); else passes++;
      checks++; if (q_count !== 3'd0) $display("[TB] FAIL reset_count: got %0d want 0", q_count); else passes++;
      checks++; if (rom_addr !== AWIDTH'(RESET_PC)) $display("[TB] FAIL reset_addr: got %0d want %0d", rom_addr, RESET_PC); else passes++;
      checks++; if (inst_data !== '0 || inst_pc !== '0) $display("[TB] FAIL reset_head: got data %0d pc %0d want 0 0", inst_data, inst_pc); else passes++;
   endtask

   task automatic test_stream();
      int k = 0;
      drive(1, 0, 0, 0, 1, 0);
      tick();
      drive(0, 0, 0, 0, 1, 0);
      checks++; if (inst_vld !== 1'b0 || rom_cs !== 1'b1) $display("[TB] FAIL stream_prime: got vld %0b cs %0b want 0 1", inst_vld, rom_cs); else passes++;
      tick();
      for (int c = 0; c < 20; c++) begin
         drive(0, 0, 0, 0, 1, 0);
         checks++;
         if (inst_vld !== 1'b1 || inst_pc !== AWIDTH'(k) || inst_data !== WIDTH'(k))
            $display("[TB] FAIL stream_word: got vld %0b pc %0d data %0d want 1 %0d %0d", inst_vld, inst_pc, inst_data, k, k);
         else passes++;
         k++;
         tick();
      end
      drive(0, 1, 0, 0, 1, 0);
      tick();
      for (int c = 0; c < 8 && mq.size() != 0; c++) begin
         drive(0, 0, 0, 0, 1, 0);
         tick();
      end
      drive(0, 0, 0, 0, 1, 0);
      checks++; if (inst_vld !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL stream_drained: got vld %0b busy %0b want 0 0", inst_vld, busy); else passes++;
   endtask

   task automatic test_stall();
      do_reset();
      drive(1, 0, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      checks++; if (rom_cs !== 1'b1 || rom_addr !== AWIDTH'(0)) $display("[TB] FAIL stall_first_fetch: got cs %0b addr %0d want 1 0", rom_cs, rom_addr); else passes++;
      tick();
      drive(0, 0, 0, 0, 0, 0);
      checks++; if (q_count !== 3'd2 || rom_cs !== 1'b1) $display("[TB] FAIL stall_second_fetch: got count %0d cs %0b want 2 1", q_count, rom_cs); else passes++;
      tick();
      drive(0, 0, 0, 0, 0, 0);
      checks++; if (q_count !== 3'd4 || rom_cs !== 1'b0 || rom_addr !== AWIDTH'(4)) $display("[TB] FAIL stall_full: got count %0d cs %0b addr %0d want 4 0 4", q_count, rom_cs, rom_addr); else passes++;
      tick();
      drive(0, 0, 0, 0, 1, 0);
      checks++; if (inst_pc !== AWIDTH'(0) || rom_cs !== 1'b0) $display("[TB] FAIL stall_pop0: got pc %0d cs %0b want 0 0", inst_pc, rom_cs); else passes++;
      tick();
      drive(0, 0, 0, 0, 1, 0);
      checks++; if (inst_pc !== AWIDTH'(1) || q_count !== 3'd3 || rom_cs !== 1'b0) $display("[TB] FAIL stall_pop1: got pc %0d count %0d cs %0b want 1 3 0", inst_pc, q_count, rom_cs); else passes++;
      tick();
      drive(0, 0, 0, 0, 1, 0);
      checks++; if (q_count !== 3'd2 || rom_cs !== 1'b1 || inst_pc !== AWIDTH'(2)) $display("[TB] FAIL stall_resume: got count %0d cs %0b pc %0d want 2 1 2", q_count, rom_cs, inst_pc); else passes++;
      tick();
   endtask

   task automatic test_redirect();
      drive(0, 0, 0, 0, 1, 0);
      checks++; if (q_count !== 3'd3) $display("[TB] FAIL redir_precount: got %0d want 3", q_count); else passes++;
      drive(0, 0, 1, 'h100, 1, 0);
      checks++; if (inst_vld !== 1'b0 || rom_cs !== 1'b0) $display("[TB] FAIL redir_cycle: got vld %0b cs %0b want 0 0", inst_vld, rom_cs); else passes++;
      tick();
      drive(0, 0, 0, 0, 1, 0);
      checks++; if (q_count !== 3'd0 || rom_addr !== AWIDTH'('h100)) $display("[TB] FAIL redir_flush: got count %0d addr %0d want 0 256", q_count, rom_addr); else passes++;
      tick();
      drive(0, 0, 0, 0, 1, 0);
      checks++; if (inst_vld !== 1'b1 || inst_pc !== AWIDTH'('h100)) $display("[TB] FAIL redir_first: got vld %0b pc %0d want 1 256", inst_vld, inst_pc); else passes++;
      tick();
   endtask

   task automatic test_wrap();
      drive(0, 0, 1, DEPTH - 1, 1, 0);
      tick();
      drive(0, 0, 0, 0, 1, 0);
      checks++; if (rom_cs !== 1'b1 || rom_addr !== AWIDTH'(DEPTH - 1)) $display("[TB] FAIL wrap_fetch: got cs %0b addr %0d want 1 %0d", rom_cs, rom_addr, DEPTH - 1); else passes++;
      tick();
      drive(0, 0, 0, 0, 1, 0);
      checks++; if (q_count !== 3'd1 || rom_addr !== AWIDTH'(0) || inst_pc !== AWIDTH'(DEPTH - 1)) $display("[TB] FAIL wrap_single: got count %0d addr %0d pc %0d want 1 0 %0d", q_count, rom_addr, inst_pc, DEPTH - 1); else passes++;
      tick();
      drive(0, 0, 0, 0, 1, 0);
      checks++; if (inst_vld !== 1'b1 || inst_pc !== AWIDTH'(0)) $display("[TB] FAIL wrap_seq0: got vld %0b pc %0d want 1 0", inst_vld, inst_pc); else passes++;
      tick();
      drive(0, 0, 0, 0, 1, 0);
      checks++; if (inst_vld !== 1'b1 || inst_pc !== AWIDTH'(1)) $display("[TB] FAIL wrap_seq1: got vld %0b pc %0d want 1 1", inst_vld, inst_pc); else passes++;
      tick();
   endtask

   task automatic test_stop();
      bit found = 1'b0;
      for (int c = 0; c < 8; c++) begin
         drive(0, 0, 0, 0, 1, 0);
         if (mq.size() == 3) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      checks++; if (!found || q_count !== 3'd3) $display("[TB] FAIL stop_setup: got count %0d want 3", q_count); else passes++;
      drive(0, 1, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      checks++; if (busy !== 1'b0 || rom_cs !== 1'b0 || q_count !== 3'd3) $display("[TB] FAIL stop_idle: got busy %0b cs %0b count %0d want 0 0 3", busy, rom_cs, q_count); else passes++;
      tick();
      for (int c = 0; c < 3; c++) begin
         drive(0, 0, 0, 0, 1, 0);
         checks++;
         if (inst_vld !== 1'b1 || rom_cs !== 1'b0 || mq.size() == 0 || inst_pc !== AWIDTH'(mq[0]))
            $display("[TB] FAIL stop_drain: got vld %0b cs %0b pc %0d want 1 0 %0d", inst_vld, rom_cs, inst_pc, (mq.size() != 0) ? mq[0] : -1);
         else passes++;
         tick();
      end
      drive(0, 0, 0, 0, 1, 0);
      checks++; if (inst_vld !== 1'b0 || q_count !== 3'd0) $display("[TB] FAIL stop_empty: got vld %0b count %0d want 0 0", inst_vld, q_count); else passes++;
      drive(1, 1, 0, 0, 1, 0);
      tick();
      drive(0, 0, 0, 0, 1, 0);
      checks++; if (busy !== 1'b0 || rom_cs !== 1'b0) $display("[TB] FAIL start_stop_same: got busy %0b cs %0b want 0 0", busy, rom_cs); else passes++;
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive(1, 0, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 1, 1);
      checks++; if (q_count !== 3'd2) $display("[TB] FAIL rstmid_pre: got count %0d want 2", q_count); else passes++;
      tick();
      drive(0, 0, 0, 0, 1, 0);
      checks++;
      if (inst_vld !== 1'b0 || q_count !== 3'd0 || rom_addr !== AWIDTH'(RESET_PC) || busy !== 1'b0)
         $display("[TB] FAIL rstmid_post: got vld %0b count %0d addr %0d busy %0b want 0 0 %0d 0", inst_vld, q_count, rom_addr, busy, RESET_PC);
      else passes++;
      tick();
   endtask

   task automatic test_random();
      bit st, sp, rv, rdy, rs;
      int rpc;
      for (int c = 0; c < 1500; c++) begin
         st  = ($urandom_range(0, 7) == 0);
         sp  = ($urandom_range(0, 15) == 0);
         rv  = ($urandom_range(0, 19) == 0);
         rdy = ($urandom_range(0, 3) != 0);
         rs  = ($urandom_range(0, 299) == 0);
         case ($urandom_range(0, 3))
            0:       rpc = DEPTH - 1;
            1:       rpc = DEPTH - 2;
            default: rpc = $urandom_range(0, 2 * DEPTH - 1);
         endcase
         drive(st, sp, rv, rpc, rdy, rs);
         checks++; if (inst_vld !== exp_vld) $display("[TB] FAIL rand_vld: got %0b want %0b", inst_vld, exp_vld); else passes++;
         checks++; if (rom_cs !== exp_cs) $display("[TB] FAIL rand_cs: got %0b want %0b", rom_cs, exp_cs); else passes++;
         checks++; if (rom_addr !== AWIDTH'(m_pc)) $display("[TB] FAIL rand_addr: got %0d want %0d", rom_addr, m_pc); else passes++;
         checks++; if (q_count !== 3'(mq.size())) $display("[TB] FAIL rand_count: got %0d want %0d", q_count, mq.size()); else passes++;
         checks++; if (busy !== m_fetch) $display("[TB] FAIL rand_busy: got %0b want %0b", busy, m_fetch); else passes++;
         if (exp_vld) begin
            checks++;
            if (inst_pc !== AWIDTH'(mq[0]) || inst_data !== WIDTH'(mq[0]))
               $display("[TB] FAIL rand_head: got pc %0d data %0d want %0d", inst_pc, inst_data, mq[0]);
            else passes++;
         end
         tick();
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_wrap();
      test_stop();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
